// File: rtl/chan_fifo_pkg.sv
// Shared constants and helpers for the channel FIFO bank.
package chan_fifo_pkg;

  localparam logic [6:0] STAT_H2F_BASE = 7'h40;
  localparam logic [6:0] STAT_F2H_BASE = 7'h60;
  localparam logic [6:0] STAT_MASK     = 7'h60;
  localparam int         FLUSH_H2F_BIT = 0;
  localparam int         FLUSH_F2H_BIT = 1;

  // A depth counter must hold 0..2^depthLog2 inclusive.
  function automatic int depthWidth(input int depthLog2);
    return depthLog2 + 1;
  endfunction

endpackage

// File: rtl/chan_fifo_bank_fifo_core.sv
// Synchronous byte FIFO with first-word fall-through head, flush and depth output.
module fifo_core
  import chan_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  localparam int DW = depthWidth(DEPTH_LOG2)
) (
  input  logic          clk_in,
  input  logic          resetN_in,
  input  logic          flush_in,
  input  logic [7:0]    pushData,
  input  logic          pushValid,
  output logic          pushReady,
  output logic [7:0]    popData,
  output logic          popValid,
  input  logic          popReady,
  output logic [DW-1:0] depth_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [DW-1:0]         depth;
  logic                  doPush, doPop;

  assign pushReady = (depth != DW'(DEPTH));
  assign popValid  = (depth != '0);
  // Mask the head so an empty FIFO presents 0x00 instead of stale RAM.
  assign popData   = popValid ? mem[rdPtr] : 8'h00;
  assign depth_out = depth;
  assign doPush    = pushValid && pushReady;
  assign doPop     = popValid && popReady;

  always_ff @(posedge clk_in or negedge resetN_in) begin
    if (!resetN_in) begin
      wrPtr <= '0;
      rdPtr <= '0;
      depth <= '0;
    end else if (flush_in) begin
      wrPtr <= '0;
      rdPtr <= '0;
      depth <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + DEPTH_LOG2'(1);
      if (doPop)  rdPtr <= rdPtr + DEPTH_LOG2'(1);
      case ({doPush, doPop})
        2'b10:   depth <= depth + DW'(1);
        2'b01:   depth <= depth - DW'(1);
        default: depth <= depth;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (doPush && !flush_in) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/chan_fifo_bank.sv
// Bank of NUM_CHANS h2f/f2h FIFO pairs behind the host channel interface.
// Build option: define CHAN_FIFO_FLUSH_EN to enable host-commanded flush via 0x40+k writes.
module chan_fifo_bank
  import chan_fifo_pkg::*;
#(
  parameter int NUM_CHANS  = 2,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk_in,
  input  logic                   resetN_in,
  input  logic [6:0]             chanAddr_in,
  input  logic [7:0]             h2fData_in,
  input  logic                   h2fValid_in,
  output logic                   h2fReady_out,
  output logic [7:0]             f2hData_out,
  output logic                   f2hValid_out,
  input  logic                   f2hReady_in,
  output logic [8*NUM_CHANS-1:0] fabOutData_out,
  output logic [NUM_CHANS-1:0]   fabOutValid_out,
  input  logic [NUM_CHANS-1:0]   fabOutReady_in,
  input  logic [8*NUM_CHANS-1:0] fabInData_in,
  input  logic [NUM_CHANS-1:0]   fabInValid_in,
  output logic [NUM_CHANS-1:0]   fabInReady_out
);

  localparam int         DW = depthWidth(DEPTH_LOG2);
  localparam logic [6:0] NC = 7'(NUM_CHANS);

  logic [NUM_CHANS-1:0][7:0]    h2fHead, f2hHead, fabInData;
  logic [NUM_CHANS-1:0][DW-1:0] h2fDepth, f2hDepth;
  logic [NUM_CHANS-1:0]         h2fPush, h2fReady, f2hPop, f2hValid, h2fFlush, f2hFlush;

  logic [3:0] idx;
  logic       isData, isStatH2f, isStatF2h;

  assign idx       = chanAddr_in[3:0];
  assign isData    = chanAddr_in < NC;
  // Status windows are 32 channels wide; only the first NUM_CHANS are mapped.
  assign isStatH2f = ((chanAddr_in & STAT_MASK) == STAT_H2F_BASE) && ({2'b00, chanAddr_in[4:0]} < NC);
  assign isStatF2h = ((chanAddr_in & STAT_MASK) == STAT_F2H_BASE) && ({2'b00, chanAddr_in[4:0]} < NC);

  assign fabOutData_out = h2fHead;
  assign fabInData      = fabInData_in;

  for (genvar k = 0; k < NUM_CHANS; k++) begin : gLane
    logic sel;
    assign sel        = (idx == 4'(k));
    assign h2fPush[k] = h2fValid_in && isData && sel;
    assign f2hPop[k]  = f2hReady_in && isData && sel;
`ifdef CHAN_FIFO_FLUSH_EN
    assign h2fFlush[k] = h2fValid_in && isStatH2f && sel && h2fData_in[FLUSH_H2F_BIT];
    assign f2hFlush[k] = h2fValid_in && isStatH2f && sel && h2fData_in[FLUSH_F2H_BIT];
`else
    assign h2fFlush[k] = 1'b0;
    assign f2hFlush[k] = 1'b0;
`endif

    fifo_core #(.DEPTH_LOG2(DEPTH_LOG2)) uH2f (
      .clk_in    (clk_in),
      .resetN_in (resetN_in),
      .flush_in  (h2fFlush[k]),
      .pushData  (h2fData_in),
      .pushValid (h2fPush[k]),
      .pushReady (h2fReady[k]),
      .popData   (h2fHead[k]),
      .popValid  (fabOutValid_out[k]),
      .popReady  (fabOutReady_in[k]),
      .depth_out (h2fDepth[k])
    );

    fifo_core #(.DEPTH_LOG2(DEPTH_LOG2)) uF2h (
      .clk_in    (clk_in),
      .resetN_in (resetN_in),
      .flush_in  (f2hFlush[k]),
      .pushData  (fabInData[k]),
      .pushValid (fabInValid_in[k]),
      .pushReady (fabInReady_out[k]),
      .popData   (f2hHead[k]),
      .popValid  (f2hValid[k]),
      .popReady  (f2hPop[k]),
      .depth_out (f2hDepth[k])
    );
  end

  logic          selH2fReady, selF2hValid;
  logic [7:0]    selF2hHead;
  logic [DW-1:0] selH2fDepth, selF2hDepth;

  always_comb begin
    selH2fReady = 1'b0;
    selF2hValid = 1'b0;
    selF2hHead  = 8'h00;
    selH2fDepth = '0;
    selF2hDepth = '0;
    for (int k = 0; k < NUM_CHANS; k++) begin
      if (idx == 4'(k)) begin
        selH2fReady = h2fReady[k];
        selF2hValid = f2hValid[k];
        selF2hHead  = f2hHead[k];
        selH2fDepth = h2fDepth[k];
        selF2hDepth = f2hDepth[k];
      end
    end
  end

  assign h2fReady_out = isData ? selH2fReady : 1'b1;
  assign f2hValid_out = isData ? selF2hValid : 1'b1;

  always_comb begin
    f2hData_out = 8'h00;
    if (isData)         f2hData_out = selF2hHead;
    else if (isStatH2f) f2hData_out = 8'(selH2fDepth);
    else if (isStatF2h) f2hData_out = 8'(selF2hDepth);
  end

endmodule

// File: tb/tb_chan_fifo_bank.sv
// Randomized scoreboard bench for chan_fifo_bank using per-FIFO byte queues as the model.
module tb_chan_fifo_bank;

  localparam int NC  = 2;
  localparam int DL2 = 4;
  localparam int CAP = 1 << DL2;

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic [6:0]      chanAddr = 7'h40;
  logic [7:0]      h2fData = 8'h00;
  logic            h2fValid = 1'b0;
  logic            h2fReady;
  logic [7:0]      f2hData;
  logic            f2hValid;
  logic            f2hReady = 1'b0;
  logic [8*NC-1:0] fabOutData;
  logic [NC-1:0]   fabOutValid;
  logic [NC-1:0]   fabOutReady = '0;
  logic [8*NC-1:0] fabInData = '0;
  logic [NC-1:0]   fabInValid = '0;
  logic [NC-1:0]   fabInReady;

  int checks = 0;
  int errors = 0;

  logic [7:0] h2fQ [NC][$];
  logic [7:0] f2hQ [NC][$];

  chan_fifo_bank #(.NUM_CHANS(NC), .DEPTH_LOG2(DL2)) dut (
    .clk_in          (clk),
    .resetN_in       (resetN),
    .chanAddr_in     (chanAddr),
    .h2fData_in      (h2fData),
    .h2fValid_in     (h2fValid),
    .h2fReady_out    (h2fReady),
    .f2hData_out     (f2hData),
    .f2hValid_out    (f2hValid),
    .f2hReady_in     (f2hReady),
    .fabOutData_out  (fabOutData),
    .fabOutValid_out (fabOutValid),
    .fabOutReady_in  (fabOutReady),
    .fabInData_in    (fabInData),
    .fabInValid_in   (fabInValid),
    .fabInReady_out  (fabInReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", nm, $time, act, exp);
    end
  endtask

  // Scoreboard: compares what the DUT presents before each edge, then
  // retires/appends the bytes that edge will transfer.
  task automatic scoreboard();
    int c, k, hs[NC], fs[NC];
    bit dataCh, sh, sf, expValid;
    bit flushH[NC], flushF[NC];
    int expData;
    c = int'(chanAddr);
    if (!resetN) begin
      for (int i = 0; i < NC; i++) begin
        h2fQ[i].delete();
        f2hQ[i].delete();
      end
      chk("rst_fabOutValid", int'(fabOutValid), 0);
      chk("rst_fabInReady", int'(fabInReady), (1 << NC) - 1);
      chk("rst_fabOutData", int'(fabOutData), 0);
      chk("rst_h2fReady", int'(h2fReady), 1);
      if (c < NC) chk("rst_f2hValid", int'(f2hValid), 0);
      return;
    end
    dataCh = c < NC;
    sh = (c >= 'h40) && (c < 'h40 + NC);
    sf = (c >= 'h60) && (c < 'h60 + NC);
    k  = c & 15;
    for (int i = 0; i < NC; i++) begin
      hs[i] = h2fQ[i].size();
      fs[i] = f2hQ[i].size();
    end

    chk("h2fReady", int'(h2fReady), dataCh ? int'(hs[k] < CAP) : 1);
    expValid = dataCh ? (fs[k] > 0) : 1'b1;
    chk("f2hValid", int'(f2hValid), int'(expValid));
    if (expValid) begin
      expData = dataCh ? int'(f2hQ[k][0]) : sh ? hs[k] : sf ? fs[k] : 0;
      chk("f2hData", int'(f2hData), expData);
    end
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("fabOutValid%0d", i), int'(fabOutValid[i]), int'(hs[i] > 0));
      if (hs[i] > 0) chk($sformatf("fabOutData%0d", i), int'(fabOutData[8*i +: 8]), int'(h2fQ[i][0]));
      chk($sformatf("fabInReady%0d", i), int'(fabInReady[i]), int'(fs[i] < CAP));
    end

    for (int i = 0; i < NC; i++) begin
      flushH[i] = 1'b0;
      flushF[i] = 1'b0;
    end
`ifdef CHAN_FIFO_FLUSH_EN
    if (h2fValid && sh) begin
      flushH[k] = h2fData[0];
      flushF[k] = h2fData[1];
    end
`endif
    for (int i = 0; i < NC; i++) begin
      if (flushH[i]) h2fQ[i].delete();
      else begin
        if (fabOutReady[i] && hs[i] > 0) void'(h2fQ[i].pop_front());
        if (h2fValid && dataCh && k == i && hs[i] < CAP) h2fQ[i].push_back(h2fData);
      end
      if (flushF[i]) f2hQ[i].delete();
      else begin
        if (f2hReady && dataCh && k == i && fs[i] > 0) void'(f2hQ[i].pop_front());
        if (fabInValid[i] && fs[i] < CAP) f2hQ[i].push_back(fabInData[8*i +: 8]);
      end
    end
  endtask

  always @(negedge clk) scoreboard();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h2fValid = 1'b0;
    f2hReady = 1'b0;
    fabOutReady = '0;
    fabInValid = '0;
  endtask

  initial begin
    // Reset with idle inputs; status channel 0x40 selected.
    step(); step();
    resetN = 1'b1;
    step();
    chanAddr = 7'h60; step();
    chanAddr = 7'h00; step();

    // Fill h2f FIFO 1 to full, one extra write is refused; read depth, then drain.
    chanAddr = 7'h01;
    for (int i = 0; i <= CAP; i++) begin
      h2fData = 8'(i); h2fValid = 1'b1; step();
    end
    h2fValid = 1'b0; chanAddr = 7'h41; step();
    fabOutReady = 2'b10;
    for (int i = 0; i < CAP; i++) step();
    idle(); step();

    // Single fabric push on pair 0, visible the cycle after, then popped.
    chanAddr = 7'h00; fabInData = 16'h00A5; fabInValid = 2'b01; step();
    fabInValid = 2'b00; step();
    f2hReady = 1'b1; step();
    f2hReady = 1'b0; step();

    // 8 deep then concurrent push/pop across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      h2fData = 8'(8'h80 + i); h2fValid = 1'b1; step();
    end
    fabOutReady = 2'b01;
    for (int i = 0; i < 40; i++) begin
      h2fData = 8'($urandom); step();
    end
    idle(); chanAddr = 7'h40; step();
    fabOutReady = 2'b01; chanAddr = 7'h00; for (int i = 0; i < 8; i++) step();
    idle();

    // Unmapped read and write.
    chanAddr = 7'h05; f2hReady = 1'b1; step();
    f2hReady = 1'b0; chanAddr = 7'h7F; h2fData = 8'h55; h2fValid = 1'b1; step();
    h2fValid = 1'b0;

    // f2h pair 1 to depth 5, then flush command coincident with a fabric push.
    fabInValid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      fabInData = {8'(8'h30 + i), 8'h00}; step();
    end
    chanAddr = 7'h41; h2fData = 8'h02; h2fValid = 1'b1; fabInData = 16'hEE00; step();
    idle(); chanAddr = 7'h61; step();
    chanAddr = 7'h01; f2hReady = 1'b1; for (int i = 0; i < 8; i++) step();
    idle();

    // Reset asserted mid-transfer.
    chanAddr = 7'h00; h2fValid = 1'b1; fabInValid = 2'b11; fabOutReady = 2'b11; step();
    resetN = 1'b0; step(); step();
    idle(); resetN = 1'b1; step();

    // Randomized traffic, alternating fill-heavy and drain-heavy blocks.
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit fill;
      fill = ((i / 200) % 2) == 0;
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    chanAddr = 7'(r);
        2:       chanAddr = 7'h40;
        3:       chanAddr = 7'h41;
        4:       chanAddr = 7'h60;
        5:       chanAddr = 7'h61;
        6:       chanAddr = 7'($urandom);
        default: chanAddr = 7'($urandom_range(0, NC - 1));
      endcase
      h2fData  = 8'($urandom);
      h2fValid = ($urandom_range(0, 3) != 0) ? fill : !fill;
      f2hReady = ($urandom_range(0, 3) != 0) ? !fill : fill;
      for (int j = 0; j < NC; j++) begin
        fabOutReady[j] = ($urandom_range(0, 3) == 0) ? fill : !fill;
        fabInValid[j]  = ($urandom_range(0, 3) == 0) ? !fill : fill;
      end
      fabInData = 16'($urandom);
      step();
    end
    idle(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
